alu_cmd_sequencer: RTL and testbench

- Initiator-side driver for the team's clocked 8-bit ALU (A, B, 4-bit ALU_Sel in; registered ALU_Out).
- Accepts operation commands over a valid/ready interface and drives the ALU operand and select inputs.
- Waits the ALU pipeline latency, captures ALU_Out, and returns each result over a valid/ready response interface.
- Optional sweep mode issues all 16 opcodes for one operand pair. Sits between a test/control master and the ALU.

---
 rtl/alu_pkg.sv | 31 +++
 rtl/alu_cmd_sequencer.sv | 113 +++++++++++
 tb/tb_alu_cmd_sequencer.sv | 267 ++++++++++++++++++++++++++
 3 files changed

// File: rtl/alu_pkg.sv
// Shared definitions for the ALU command sequencer: datapath widths,
// opcode encodings of the clocked 8-bit ALU, and the sequencer state type.
package alu_pkg;

  localparam int ALU_WIDTH = 8;
  localparam int ALU_SEL_W = 4;

  localparam logic [ALU_SEL_W-1:0] OP_ADD  = 4'h0;
  localparam logic [ALU_SEL_W-1:0] OP_SUB  = 4'h1;
  localparam logic [ALU_SEL_W-1:0] OP_MUL  = 4'h2;
  localparam logic [ALU_SEL_W-1:0] OP_DIV  = 4'h3;
  localparam logic [ALU_SEL_W-1:0] OP_SHL  = 4'h4;
  localparam logic [ALU_SEL_W-1:0] OP_SHR  = 4'h5;
  localparam logic [ALU_SEL_W-1:0] OP_ROL  = 4'h6;
  localparam logic [ALU_SEL_W-1:0] OP_ROR  = 4'h7;
  localparam logic [ALU_SEL_W-1:0] OP_AND  = 4'h8;
  localparam logic [ALU_SEL_W-1:0] OP_OR   = 4'h9;
  localparam logic [ALU_SEL_W-1:0] OP_XOR  = 4'hA;
  localparam logic [ALU_SEL_W-1:0] OP_NOR  = 4'hB;
  localparam logic [ALU_SEL_W-1:0] OP_NAND = 4'hC;
  localparam logic [ALU_SEL_W-1:0] OP_XNOR = 4'hD;
  localparam logic [ALU_SEL_W-1:0] OP_GT   = 4'hE;
  localparam logic [ALU_SEL_W-1:0] OP_EQ   = 4'hF;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_WAIT = 2'd1,
    ST_RESP = 2'd2
  } seq_state_t;

endpackage

// File: rtl/alu_cmd_sequencer.sv
// Initiator-side driver for the clocked ALU. Takes one command (single op or
// a 16-opcode sweep), drives the ALU operands, waits out the ALU latency,
// captures ALU_Out and returns each result on a response channel.
//
// Handshake rule (both channels): a transfer happens on a rising clk edge
// where valid and ready are both high; the source holds its payload stable
// while valid is high and ready is low, and never withdraws valid before the
// transfer.
module alu_cmd_sequencer
  import alu_pkg::*;
#(
  parameter int WIDTH   = ALU_WIDTH,
  parameter int SEL_W   = ALU_SEL_W,
  parameter int ALU_LAT = 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             cmd_valid,
  output logic             cmd_ready,
  input  logic [WIDTH-1:0] cmd_a,
  input  logic [WIDTH-1:0] cmd_b,
  input  logic [SEL_W-1:0] cmd_sel,
  input  logic             cmd_sweep,
  output logic [WIDTH-1:0] alu_a,
  output logic [WIDTH-1:0] alu_b,
  output logic [SEL_W-1:0] alu_sel,
  input  logic [WIDTH-1:0] alu_out,
  output logic             rsp_valid,
  input  logic             rsp_ready,
  output logic [SEL_W-1:0] rsp_sel,
  output logic [WIDTH-1:0] rsp_result,
  output logic             rsp_last,
  output logic             busy,
  output logic [1:0]       dbg_state
);

  // Counter is wide enough for the largest legal latency (15).
  localparam logic [3:0]       LAT      = 4'(ALU_LAT);
  localparam logic [SEL_W-1:0] SEL_LAST = {SEL_W{1'b1}};

  seq_state_t state;
  logic [3:0] cnt;
  logic       sweep_q;

  assign dbg_state = state;

  // Sequencer FSM with all outputs registered; reset aborts any command.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= ST_IDLE;
      cnt        <= '0;
      sweep_q    <= 1'b0;
      cmd_ready  <= 1'b0;
      busy       <= 1'b0;
      alu_a      <= '0;
      alu_b      <= '0;
      alu_sel    <= '0;
      rsp_valid  <= 1'b0;
      rsp_sel    <= '0;
      rsp_result <= '0;
      rsp_last   <= 1'b0;
    end else begin
      case (state)
        ST_IDLE: begin
          cmd_ready <= 1'b1;
          if (cmd_valid && cmd_ready) begin
            alu_a     <= cmd_a;
            alu_b     <= cmd_b;
            alu_sel   <= cmd_sweep ? '0 : cmd_sel;
            sweep_q   <= cmd_sweep;
            cnt       <= '0;
            cmd_ready <= 1'b0;
            busy      <= 1'b1;
            state     <= ST_WAIT;
          end
        end

        ST_WAIT: begin
          if (cnt == LAT) begin
            rsp_result <= alu_out;
            rsp_sel    <= alu_sel;
            rsp_valid  <= 1'b1;
            rsp_last   <= !sweep_q || (alu_sel == SEL_LAST);
            state      <= ST_RESP;
          end else begin
            cnt <= cnt + 4'd1;
          end
        end

        ST_RESP: begin
          if (rsp_ready) begin
            rsp_valid <= 1'b0;
            if (sweep_q && (alu_sel != SEL_LAST)) begin
              // Next sweep step; the all-ones step ends the sweep so no wrap.
              alu_sel <= alu_sel + 1'b1;
              cnt     <= '0;
              state   <= ST_WAIT;
            end else begin
              busy      <= 1'b0;
              cmd_ready <= 1'b1;
              state     <= ST_IDLE;
            end
          end
        end

        default: begin
          state <= ST_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_alu_cmd_sequencer.sv
// Bench for alu_cmd_sequencer: a behavioural clocked ALU drives alu_out, and
// expected responses come from the opcode table applied to each command.
module tb_alu_cmd_sequencer;
  import alu_pkg::*;

  localparam int LAT = 1;

  logic       clk;
  logic       rst_n;
  logic       cmd_valid;
  logic       cmd_ready;
  logic [7:0] cmd_a;
  logic [7:0] cmd_b;
  logic [3:0] cmd_sel;
  logic       cmd_sweep;
  logic [7:0] alu_a;
  logic [7:0] alu_b;
  logic [3:0] alu_sel;
  logic [7:0] alu_out;
  logic       rsp_valid;
  logic       rsp_ready;
  logic [3:0] rsp_sel;
  logic [7:0] rsp_result;
  logic       rsp_last;
  logic       busy;
  logic [1:0] dbg_state;

  int n_checks = 0;
  int n_errors = 0;

  logic [7:0] sweep_res [16];
  logic [7:0] sweep_tbl [16] = '{8'h04, 8'hFE, 8'h03, 8'h00, 8'h02, 8'h00, 8'h02, 8'h80,
                                 8'h01, 8'h03, 8'h02, 8'hFC, 8'hFE, 8'hFD, 8'h00, 8'h00};

  alu_cmd_sequencer #(.WIDTH(8), .SEL_W(4), .ALU_LAT(LAT)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .cmd_valid  (cmd_valid),
    .cmd_ready  (cmd_ready),
    .cmd_a      (cmd_a),
    .cmd_b      (cmd_b),
    .cmd_sel    (cmd_sel),
    .cmd_sweep  (cmd_sweep),
    .alu_a      (alu_a),
    .alu_b      (alu_b),
    .alu_sel    (alu_sel),
    .alu_out    (alu_out),
    .rsp_valid  (rsp_valid),
    .rsp_ready  (rsp_ready),
    .rsp_sel    (rsp_sel),
    .rsp_result (rsp_result),
    .rsp_last   (rsp_last),
    .busy       (busy),
    .dbg_state  (dbg_state)
  );

  // Clock / reset block
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Opcode table of the team ALU.
  function automatic logic [7:0] alu_f(input logic [7:0] a, input logic [7:0] b,
                                       input logic [3:0] s);
    logic [15:0] prod;
    prod = 16'(a) * 16'(b);
    case (s)
      OP_ADD:  return a + b;
      OP_SUB:  return a - b;
      OP_MUL:  return prod[7:0];
      OP_DIV:  return (b == 8'd0) ? 8'd0 : a / b;
      OP_SHL:  return a << 1;
      OP_SHR:  return a >> 1;
      OP_ROL:  return {a[6:0], a[7]};
      OP_ROR:  return {a[0], a[7:1]};
      OP_AND:  return a & b;
      OP_OR:   return a | b;
      OP_XOR:  return a ^ b;
      OP_NOR:  return ~(a | b);
      OP_NAND: return ~(a & b);
      OP_XNOR: return ~(a ^ b);
      OP_GT:   return (a > b) ? 8'd1 : 8'd0;
      default: return (a == b) ? 8'd1 : 8'd0;
    endcase
  endfunction

  // Behavioural registered ALU, one cycle latency.
  always @(posedge clk) alu_out <= alu_f(alu_a, alu_b, alu_sel);

  // Watchdog
  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Driver + scoreboard for one command. stall < 0: random rsp_ready,
  // otherwise rsp_ready low for 'stall' cycles on every response.
  // poke: keep offering a junk command while the sequencer is busy.
  task automatic run_cmd(input logic [7:0] a, input logic [7:0] b, input logic [3:0] sel,
                         input logic sweep, input int stall, input logic poke,
                         output logic [7:0] last_res);
    logic [12:0] exp_q[$];
    logic [12:0] e;
    logic [7:0]  snap_res;
    logic [3:0]  snap_sel;
    logic        snap_last;
    logic        done;
    int          n;
    int          k;
    last_res = 8'h00;
    if (sweep) begin
      for (int s = 0; s < 16; s++)
        exp_q.push_back({(s == 15), 4'(s), alu_f(a, b, 4'(s))});
    end else begin
      exp_q.push_back({1'b1, sel, alu_f(a, b, sel)});
    end

    n = 0;
    while (!cmd_ready && n < 50) begin
      @(posedge clk); #1;
      n++;
    end
    chk("cmd_ready_idle", 32'(cmd_ready), 32'd1);

    cmd_a = a; cmd_b = b; cmd_sel = sel; cmd_sweep = sweep;
    cmd_valid = 1'b1;
    rsp_ready = 1'b0;
    @(posedge clk); #1;
    if (poke) begin
      cmd_a = 8'($urandom); cmd_b = 8'($urandom);
      cmd_sel = 4'($urandom); cmd_sweep = 1'($urandom);
    end else begin
      cmd_valid = 1'b0;
    end
    chk("busy_after_accept", 32'(busy), 32'd1);
    chk("alu_a", 32'(alu_a), 32'(a));
    chk("alu_b", 32'(alu_b), 32'(b));
    chk("alu_sel_start", 32'(alu_sel), sweep ? 32'd0 : 32'(sel));

    while (exp_q.size() > 0) begin
      n = 0;
      while (!rsp_valid && n < 100) begin
        if (cmd_valid) chk("cmd_ready_busy", 32'(cmd_ready), 32'd0);
        @(posedge clk); #1;
        n++;
      end
      cmd_valid = 1'b0;
      chk("rsp_latency", 32'(n), 32'(LAT + 1));
      if (!rsp_valid) begin
        exp_q.delete();
        break;
      end
      e = exp_q.pop_front();
      chk("rsp_result", 32'(rsp_result), 32'(e[7:0]));
      chk("rsp_sel", 32'(rsp_sel), 32'(e[11:8]));
      chk("rsp_last", 32'(rsp_last), 32'(e[12]));
      last_res = rsp_result;
      sweep_res[rsp_sel] = rsp_result;
      snap_res = rsp_result; snap_sel = rsp_sel; snap_last = rsp_last;

      k = 0;
      done = 1'b0;
      while (!done) begin
        if (stall < 0) rsp_ready = ($urandom_range(0, 1) == 1) || (k >= 20);
        else           rsp_ready = (k >= stall);
        @(posedge clk); #1;
        if (rsp_ready) begin
          done = 1'b1;
        end else begin
          chk("hold_valid", 32'(rsp_valid), 32'd1);
          chk("hold_result", 32'(rsp_result), 32'(snap_res));
          chk("hold_sel", 32'(rsp_sel), 32'(snap_sel));
          chk("hold_alu_sel", 32'(alu_sel), 32'(snap_sel));
          chk("hold_last", 32'(rsp_last), 32'(snap_last));
        end
        k++;
      end
      rsp_ready = 1'b0;
    end
    chk("end_busy", 32'(busy), 32'd0);
    chk("end_rsp_valid", 32'(rsp_valid), 32'd0);
    chk("end_cmd_ready", 32'(cmd_ready), 32'd1);
  endtask

  // Main stimulus
  initial begin
    logic [7:0] res;
    int n;
    rst_n = 1'b0;
    cmd_valid = 1'b0; cmd_a = '0; cmd_b = '0; cmd_sel = '0; cmd_sweep = 1'b0;
    rsp_ready = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    chk("reset_cmd_ready", 32'(cmd_ready), 32'd0);
    chk("reset_busy", 32'(busy), 32'd0);
    chk("reset_rsp_valid", 32'(rsp_valid), 32'd0);
    chk("reset_alu_sel", 32'(alu_sel), 32'd0);
    chk("reset_rsp_result", 32'(rsp_result), 32'd0);
    @(negedge clk) rst_n = 1'b1;
    repeat (2) begin @(posedge clk); #1; end
    chk("post_reset_cmd_ready", 32'(cmd_ready), 32'd1);
    chk("post_reset_busy", 32'(busy), 32'd0);

    // Single ADD
    run_cmd(8'h01, 8'h03, OP_ADD, 1'b0, 0, 1'b0, res);
    chk("single_add", 32'(res), 32'h04);

    // Full sweep against the known result table
    run_cmd(8'h01, 8'h03, 4'h0, 1'b1, 0, 1'b0, res);
    for (int s = 0; s < 16; s++) chk("sweep_table", 32'(sweep_res[s]), 32'(sweep_tbl[s]));

    // Backpressure on SUB
    run_cmd(8'h01, 8'h03, OP_SUB, 1'b0, 5, 1'b0, res);
    chk("backpressure_sub", 32'(res), 32'hFE);

    // Command offered while busy is dropped
    run_cmd(8'h55, 8'h0F, OP_XOR, 1'b0, 2, 1'b1, res);
    chk("busy_reject_xor", 32'(res), 32'h5A);

    // Randomized commands
    for (int i = 0; i < 25; i++) begin
      run_cmd(8'($urandom), 8'($urandom), 4'($urandom), ($urandom_range(0, 3) == 0),
              -1, 1'($urandom), res);
    end

    // Reset in the middle of a sweep
    n = 0;
    while (!cmd_ready && n < 50) begin @(posedge clk); #1; n++; end
    cmd_a = 8'h01; cmd_b = 8'h03; cmd_sel = 4'h0; cmd_sweep = 1'b1; cmd_valid = 1'b1;
    @(posedge clk); #1;
    cmd_valid = 1'b0;
    rsp_ready = 1'b1;
    n = 0;
    while (!(rsp_valid && rsp_sel == 4'd7) && n < 200) begin @(posedge clk); #1; n++; end
    chk("abort_reached_sel7", 32'(rsp_sel), 32'd7);
    #2 rst_n = 1'b0;
    #1;
    chk("abort_rsp_valid", 32'(rsp_valid), 32'd0);
    chk("abort_busy", 32'(busy), 32'd0);
    chk("abort_rsp_sel", 32'(rsp_sel), 32'd0);
    chk("abort_alu_sel", 32'(alu_sel), 32'd0);
    chk("abort_rsp_last", 32'(rsp_last), 32'd0);
    rsp_ready = 1'b0;
    @(negedge clk) rst_n = 1'b1;
    for (int i = 0; i < 4; i++) begin
      @(posedge clk); #1;
      chk("abort_no_rsp", 32'(rsp_valid), 32'd0);
    end
    chk("abort_cmd_ready", 32'(cmd_ready), 32'd1);
    run_cmd(8'h0F, 8'h3C, OP_AND, 1'b0, 0, 1'b0, res);
    chk("after_abort_and", 32'(res), 32'h0C);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
